// File: rtl/bidirectional_port.sv
// -----------------------------------------------------------------------------
// bidirectional_port
//
// Memory-mapped general-purpose I/O port with per-bit direction control,
// tri-state pin drivers, a two-flop input synchronizer, a tick-based
// debouncer and rising-edge interrupts with write-one-to-clear pending bits.
//
// Register map (addr):
//   0 DATA      write: output register; read: per-bit debounced input,
//               output register or 0 depending on ENABLE/CONFIG
//   1 CONFIG    1 = input, 0 = output
//   2 ENABLE    1 = bit in use
//   3 IRQ_EN    interrupt mask
//   4 IRQ_PEND  pending interrupts, write 1 to clear
//   5-7         reserved: writes ignored, reads return 0
//
// Ports:
//   sys_clk   only clock, rising edge
//   rst_sync  asynchronous active-high reset
//   ce, wr    bus chip enable / write strobe (ce=1,wr=0 is a read)
//   addr      register select
//   data_in   write data
//   data_out  combinational read data (0 when not reading)
//   irq       OR of pending & enabled interrupts
//   port_io   external pins, tri-stated unless enabled as outputs
// -----------------------------------------------------------------------------
module bidirectional_port #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 100
) (
    input  logic                  sys_clk,
    input  logic                  rst_sync,
    input  logic                  ce,
    input  logic                  wr,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  irq,
    inout  wire  [DATA_WIDTH-1:0] port_io
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_CONFIG   = 3'd1;
    localparam logic [2:0] ADDR_ENABLE   = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_PEND = 3'd4;

    // Software-visible registers
    logic [DATA_WIDTH-1:0] out_q,  out_d;
    logic [DATA_WIDTH-1:0] cfg_q,  cfg_d;
    logic [DATA_WIDTH-1:0] en_q,   en_d;
    logic [DATA_WIDTH-1:0] ien_q,  ien_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;

    // Input path: synchronizer, debounce sampler, edge detect
    logic [DATA_WIDTH-1:0] sync1_q,    sync1_d;
    logic [DATA_WIDTH-1:0] sync2_q,    sync2_d;
    logic [DATA_WIDTH-1:0] sample_q,   sample_d;
    logic [DATA_WIDTH-1:0] deb_q,      deb_d;
    logic [DATA_WIDTH-1:0] deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    logic                  tick;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] pend_clr;
    logic [DATA_WIDTH-1:0] pend_set;
    logic [DATA_WIDTH-1:0] agree;
    logic [DATA_WIDTH-1:0] drive;
    logic [DATA_WIDTH-1:0] data_view;

    // -------------------------------------------------------------------------
    // Bus writes and interrupt pending
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        out_d    = out_q;
        cfg_d    = cfg_q;
        en_d     = en_q;
        ien_d    = ien_q;
        pend_clr = '0;
        wr_en    = ce & wr;

        if (wr_en) begin
            case (addr)
                ADDR_DATA:     out_d    = data_in;
                ADDR_CONFIG:   cfg_d    = data_in;
                ADDR_ENABLE:   en_d     = data_in;
                ADDR_IRQ_EN:   ien_d    = data_in;
                ADDR_IRQ_PEND: pend_clr = data_in;
                default:       ;
            endcase
        end

        // A debounced rising edge on an enabled input with its interrupt
        // unmasked sets pending one cycle after the edge. OR-ing the set after
        // the clear makes a coincident set win over a W1C.
        pend_set = deb_q & ~deb_prev_q & en_q & cfg_q & ien_q;
        pend_d   = (pend_q & ~pend_clr) | pend_set;
    end

    // -------------------------------------------------------------------------
    // Synchronizer and debouncer. All bits are debounced regardless of
    // ENABLE/CONFIG so that re-enabling a bit cannot create a false edge.
    // -------------------------------------------------------------------------
    always_comb begin
        tick       = (cnt_q == CNT_MAX);
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);

        sync1_d    = port_io;
        sync2_d    = sync1_q;

        // A bit is accepted only when two consecutive tick samples agree;
        // otherwise the previous debounced value is held.
        agree      = ~(sync2_q ^ sample_q);
        sample_d   = tick ? sync2_q : sample_q;
        deb_d      = tick ? ((agree & sync2_q) | (~agree & deb_q)) : deb_q;
        deb_prev_d = deb_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge rst_sync) begin
        if (rst_sync) begin
            out_q      <= '0;
            cfg_q      <= '0;
            en_q       <= '0;
            ien_q      <= '0;
            pend_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sample_q   <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others (the synchronizer chain relies on it).
            out_q      <= out_d;
            cfg_q      <= cfg_d;
            en_q       <= en_d;
            ien_q      <= ien_d;
            pend_q     <= pend_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sample_q   <= sample_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux, interrupt output and pin drivers
    // -------------------------------------------------------------------------
    always_comb begin
        rd_en     = ce & ~wr;
        data_view = en_q & ((cfg_q & deb_q) | (~cfg_q & out_q));
        data_out  = '0;
        if (rd_en) begin
            case (addr)
                ADDR_DATA:     data_out = data_view;
                ADDR_CONFIG:   data_out = cfg_q;
                ADDR_ENABLE:   data_out = en_q;
                ADDR_IRQ_EN:   data_out = ien_q;
                ADDR_IRQ_PEND: data_out = pend_q;
                default:       data_out = '0;
            endcase
        end
        irq = |(pend_q & ien_q);
    end

    // Pins are driven only by enabled outputs; since ENABLE resets
    // asynchronously, reset releases every pin without waiting for a clock.
    assign drive = en_q & ~cfg_q;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
        assign port_io[i] = drive[i] ? out_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_bidirectional_port.sv
// -----------------------------------------------------------------------------
// tb_bidirectional_port
//
// Scoreboard bench for bidirectional_port with DEBOUNCE_CYCLES=4. Register
// reads push their expected value into a queue; a monitor on the falling
// edge pops and compares whenever a tracked read is on the bus. Expected
// values come from a register-level model: pins settle to a value, and after
// a long enough quiet period the debounced value equals the pin, with any
// 0->1 change on an armed input bit raising its pending flag.
// Undriven pins are pulled up so a released pin reads 1.
// -----------------------------------------------------------------------------
module tb_bidirectional_port;

    localparam int W      = 32;
    localparam int N      = 4;
    localparam int SETTLE = 3 * N + 4;

    logic         sys_clk;
    logic         rst_sync;
    logic         ce;
    logic         wr;
    logic [2:0]   addr;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         irq;
    wire  [W-1:0] port_io;

    logic [W-1:0] tb_en;
    logic [W-1:0] tb_val;

    for (genvar i = 0; i < W; i++) begin : g_pin
        assign port_io[i] = tb_en[i] ? tb_val[i] : 1'bz;
        pullup (port_io[i]);
    end

    bidirectional_port #(
        .DATA_WIDTH      (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_sync (rst_sync),
        .ce       (ce),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq),
        .port_io  (port_io)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string        name;
        logic [W-1:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t mon_item;
    logic     sb_valid;

    // Reference model state
    logic [W-1:0] m_out, m_cfg, m_en, m_ien, m_pend, m_deb;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per tracked read cycle.
    always @(negedge sys_clk) begin
        if (sb_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got read with empty queue, expected a queued entry");
            end else begin
                mon_item = sb_q.pop_front();
                check(mon_item.name, data_out, mon_item.exp);
            end
        end
    end

    function automatic logic [W-1:0] m_drive();
        return m_en & ~m_cfg;
    endfunction

    // Pin level: DUT output if driving, else bench value if driving, else pull-up.
    function automatic logic [W-1:0] m_pins();
        logic [W-1:0] d;
        d = m_drive();
        return (d & m_out) | (~d & ((tb_en & tb_val) | ~tb_en));
    endfunction

    function automatic logic [W-1:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return (m_en & m_cfg & m_deb) | (m_en & ~m_cfg & m_out);
            3'd1:    return m_cfg;
            3'd2:    return m_en;
            3'd3:    return m_ien;
            3'd4:    return m_pend;
            default: return '0;
        endcase
    endfunction

    task automatic m_reset();
        m_out = '0; m_cfg = '0; m_en = '0; m_ien = '0; m_pend = '0; m_deb = '0;
    endtask

    // Inputs change 1 time unit after the rising edge, away from sampling.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d);
        // NOTE: bench stimulus uses blocking assignments from procedural code;
        // the 1-unit offset after the edge keeps it race-free with the DUT.
        ce = 1'b1; wr = 1'b1; addr = a; data_in = d;
        cyc();
        ce = 1'b0; wr = 1'b0;
        case (a)
            3'd0:    m_out  = d;
            3'd1:    m_cfg  = d;
            3'd2:    m_en   = d;
            3'd3:    m_ien  = d;
            3'd4:    m_pend = m_pend & ~d;
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a, input string name);
        sb_item_t item;
        item.name = name;
        item.exp  = m_read(a);
        sb_q.push_back(item);
        ce = 1'b1; wr = 1'b0; addr = a; sb_valid = 1'b1;
        cyc();
        ce = 1'b0; sb_valid = 1'b0;
    endtask

    // Wait long enough for any pin change to pass the debouncer, then
    // advance the model: debounced follows pins, armed rises set pending.
    task automatic settle();
        logic [W-1:0] p;
        repeat (SETTLE) cyc();
        p      = m_pins();
        m_pend = m_pend | (~m_deb & p & m_en & m_cfg & m_ien);
        m_deb  = p;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic         seen;
        logic         found;
        int           op;
        logic [2:0]   ra;
        logic [W-1:0] rd;

        rst_sync = 1'b1; ce = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        tb_en = '0; tb_val = '0; sb_valid = 1'b0;
        m_reset();

        // Reset state, held 50 ns
        #20;
        check("rst_irq", W'(irq), '0);
        check("rst_port_io_z", port_io, m_pins());
        ce = 1'b1; wr = 1'b0; addr = 3'd1;
        #1;
        check("rst_data_out", data_out, '0);
        ce = 1'b0;
        #29;
        rst_sync = 1'b0;
        cyc();
        for (int a = 0; a < 8; a++) bus_read(3'(a), $sformatf("post_rst_read_a%0d", a));
        check("post_rst_irq", W'(irq), '0);
        check("post_rst_port_io_z", port_io, m_pins());
        settle();

        // Mixed direction: low three bits inputs, rest of the byte outputs
        bus_write(3'd1, 32'h7);
        bus_write(3'd2, 32'hFF);
        bus_write(3'd0, 32'hA5);
        settle();
        check("pins_7_3_driven", W'(port_io[7:3]), W'(5'b10100));
        check("pins_full", port_io, m_pins());
        bus_read(3'd0, "data_mixed");

        // Rising input on bit 2 with its interrupt unmasked
        tb_en = 32'h7; tb_val = 32'h0;
        settle();
        bus_write(3'd3, 32'h4);
        tb_val = 32'h4;
        ce = 1'b1; wr = 1'b0; addr = 3'd0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (data_out[2]) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat < N + 3 || lat > 2 * N + 2) begin
            n_errors++;
            $display("FAIL deb_latency: got %0d cycles expected %0d..%0d", lat, N + 3, 2 * N + 2);
        end
        check("irq_before_pend", W'(irq), '0);
        cyc();
        check("irq_after_pend", W'(irq), W'(1'b1));
        ce = 1'b0;
        repeat (30) cyc();
        settle();
        bus_read(3'd4, "pend_after_edge");
        check("irq_pending", W'(irq), W'(|(m_pend & m_ien)));
        bus_write(3'd4, 32'h4);
        check("irq_after_w1c", W'(irq), W'(|(m_pend & m_ien)));
        bus_read(3'd4, "pend_after_w1c");

        // Short glitch on bit 1 must not pass the debouncer
        bus_write(3'd3, 32'h6);
        tb_val[1] = 1'b1;
        cyc();
        cyc();
        tb_val[1] = 1'b0;
        ce = 1'b1; wr = 1'b0; addr = 3'd0;
        seen = 1'b0;
        repeat (SETTLE) begin
            cyc();
            seen = seen | data_out[1];
        end
        ce = 1'b0;
        check("glitch_data_bit1", W'(seen), '0);
        settle();
        bus_read(3'd0, "data_after_glitch");
        bus_read(3'd4, "pend_after_glitch");

        // Debounced edge on bit 0 lands in the same cycle as a W1C of bit 0
        bus_write(3'd3, 32'h7);
        tb_val[0] = 1'b1;
        ce = 1'b1; wr = 1'b0; addr = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (data_out[0]) begin
                found = 1'b1;
                wr = 1'b1; addr = 3'd4; data_in = 32'h1;
                cyc();
                break;
            end
        end
        ce = 1'b0; wr = 1'b0;
        check("edge_found_bit0", W'(found), W'(1'b1));
        m_pend = m_pend & ~32'h1;
        settle();
        bus_read(3'd4, "pend_set_wins");
        check("irq_set_wins", W'(irq), W'(|(m_pend & m_ien)));

        // Asynchronous reset between edges while pins are driven
        check("pins_before_rst", port_io, m_pins());
        check("irq_before_rst", W'(irq), W'(1'b1));
        ce = 1'b1; wr = 1'b0; addr = 3'd1;
        @(posedge sys_clk);
        #3;
        rst_sync = 1'b1;
        #1;
        m_reset();
        check("async_rst_pins_z", port_io, m_pins());
        check("async_rst_irq", W'(irq), '0);
        check("async_rst_data_out", data_out, '0);
        #20;
        rst_sync = 1'b0;
        ce = 1'b0;
        cyc();
        settle();
        bus_read(3'd1, "cfg_after_rst");
        bus_read(3'd0, "data_after_rst");

        // Randomized register traffic with random external pin drive
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 9));
            ra = 3'($urandom_range(0, 7));
            if (op < 6) begin
                rd = $urandom;
                bus_write(ra, rd);
                tb_en  = $urandom & ~m_drive();
                tb_val = $urandom;
                settle();
                check("rand_pins", port_io, m_pins());
                check("rand_irq_w", W'(irq), W'(|(m_pend & m_ien)));
            end else begin
                bus_read(ra, $sformatf("rand_read_a%0d", ra));
                check("rand_irq_r", W'(irq), W'(|(m_pend & m_ien)));
            end
        end
        for (int a = 0; a < 8; a++) bus_read(3'(a), $sformatf("final_read_a%0d", a));

        cyc();
        check("sb_drained", W'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
